// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time loader that sits in front of the instruction memory and the core.
//   It accepts a framed byte stream, assembles little-endian 32-bit words,
//   writes them into instruction memory, and keeps the core in reset until a
//   complete image with a matching XOR checksum has been received.
//
//   Frame: 4 header bytes (word count N, LSB first), N*4 payload bytes
//   (each word LSB first), 1 checksum byte (XOR of every payload byte).
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
//   rx_ready depends only on the loader state (and is held low during reset),
//   never on rx_valid; the sender may hold rx_valid and rx_data indefinitely.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   rx_data     incoming byte
//   rx_valid    rx_data is valid
//   rx_ready    loader can take a byte (HDR, LOAD, CHK)
//   start       one-cycle pulse: restart a load from DONE or ERROR
//   imem_we     instruction memory write strobe, one cycle per word
//   imem_addr   byte address of the write (low two bits zero)
//   imem_wdata  instruction word being written
//   core_reset  active-high core reset, low only in DONE
//   busy        frame in progress (first header byte seen, not DONE/ERROR)
//   error       sticky error flag
//   err_code    0 none, 1 length overflow, 2 checksum mismatch, 3 timeout
//   dbg_state   current FSM state for debug / assertion binding
module imem_boot_loader #(
  parameter int ADDR_BITS = 10,
  parameter int BASE_WORD = 0,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 start,
  output logic                 imem_we,
  output logic [ADDR_BITS+1:0] imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  // Largest word count that still fits above BASE_WORD.
  localparam logic [32:0]   LIMIT    = 33'(2 ** ADDR_BITS) - 33'(BASE_WORD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t               state;
  logic [1:0]           byte_cnt;   // byte position within header or word
  logic [31:0]          n_words;    // header word count, shifted in LSB first
  logic [ADDR_BITS:0]   word_idx;   // words written so far in this frame
  logic [7:0]           csum;
  logic [TW-1:0]        tmo_cnt;
  logic [23:0]          asm_word;   // first three bytes of the current word

  logic                 xfer;
  logic [31:0]          n_full;
  logic [31:0]          word_full;
  logic [ADDR_BITS-1:0] wr_word;
  logic [31:0]          idx_next;

  assign rx_ready  = reset && (state == S_HDR || state == S_LOAD || state == S_CHK);
  assign xfer      = rx_valid && rx_ready;
  // Values as they will be once the byte on rx_data is folded in.
  assign n_full    = {rx_data, n_words[31:8]};
  assign word_full = {rx_data, asm_word};
  assign wr_word   = ADDR_BITS'(BASE_WORD) + word_idx[ADDR_BITS-1:0];
  assign idx_next  = 32'(word_idx) + 32'd1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_HDR;
      byte_cnt   <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      csum       <= '0;
      tmo_cnt    <= '0;
      asm_word   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR, S_LOAD, S_CHK: begin
          if (xfer) begin
            // An accepted byte always wins over a timeout in the same cycle.
            tmo_cnt <= '0;
            busy    <= 1'b1;
            if (state == S_HDR) begin
              n_words  <= n_full;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if ({1'b0, n_full} > LIMIT) begin
                  state    <= S_ERR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= 2'd1;
                end else if (n_full == 32'd0) begin
                  state <= S_CHK;
                end else begin
                  state <= S_LOAD;
                end
              end
            end else if (state == S_LOAD) begin
              asm_word <= word_full[31:8];
              csum     <= csum ^ rx_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                // Write fires the cycle after the last byte of the word, so
                // the final word's strobe lands in the first CHK cycle.
                imem_we    <= 1'b1;
                imem_wdata <= word_full;
                imem_addr  <= {wr_word, 2'b00};
                word_idx   <= word_idx + 1'b1;
                if (idx_next == n_words) begin
                  state <= S_CHK;
                end
              end
            end else begin
              busy <= 1'b0;
              if (rx_data == csum) begin
                state      <= S_DONE;
                core_reset <= 1'b0;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                err_code <= 2'd2;
              end
            end
          end else if (busy) begin
            // Idle cycles only count once the first header byte has arrived.
            if (tmo_cnt == TMO_LAST) begin
              state    <= S_ERR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd3;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_HDR;
            byte_cnt   <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            csum       <= '0;
            tmo_cnt    <= '0;
            asm_word   <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'd0;
          end
        end
        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader (ADDR_BITS=10, BASE_WORD=0, TIMEOUT=16).
// A frame-level model tracks how many bytes of the current frame have been
// taken and derives every expected output from the frame rules; a per-cycle
// compare process checks the DUT against it, and a write scoreboard holds
// hand-computed {address, data} pairs for each directed scenario.
module tb_imem_boot_loader;

  localparam int ADDR_BITS = 10;
  localparam int BASE_WORD = 0;
  localparam int TMO       = 16;
  localparam int MAX_N     = (2 ** ADDR_BITS) - BASE_WORD;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        start = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        error;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;

  imem_boot_loader #(
    .ADDR_BITS(ADDR_BITS),
    .BASE_WORD(BASE_WORD),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .start(start),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .busy(busy),
    .error(error),
    .err_code(err_code),
    .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected writes: {byte address, data}
  logic [43:0] exp_q[$];

  // ---------------- frame-level model ----------------
  longint      m_cnt = 0;     // bytes of the current frame taken so far
  logic [31:0] m_n = '0;      // header word count
  logic [7:0]  m_x = '0;      // running XOR of payload bytes
  logic [31:0] m_word = '0;
  bit          m_done = 1'b0;
  int          m_code = 0;
  int          m_idle = 0;
  bit          m_we = 1'b0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_rdy;
  int          m_p;
  int          m_k;

  function automatic bit model_open();
    return !m_done && m_code == 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_n = '0; m_x = '0; m_word = '0;
      m_done = 1'b0; m_code = 0; m_idle = 0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_rdy = model_open();
      m_we = 1'b0;
      if (!m_rdy) begin
        if (start) begin
          m_cnt = 0; m_n = '0; m_x = '0; m_word = '0;
          m_done = 1'b0; m_code = 0; m_idle = 0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        m_p = int'(m_cnt);
        if (m_cnt < 4) begin
          m_n[m_p*8 +: 8] = rx_data;
          if (m_p == 3 && m_n > 32'(MAX_N)) m_code = 1;
        end else if (m_cnt < 4 + 4 * longint'(m_n)) begin
          m_k = m_p - 4;
          m_word[(m_k % 4)*8 +: 8] = rx_data;
          m_x = m_x ^ rx_data;
          if (m_k % 4 == 3) begin
            m_we = 1'b1;
            m_addr = 12'((BASE_WORD + m_k / 4) * 4);
            m_data = m_word;
          end
        end else begin
          if (rx_data == m_x) m_done = 1'b1;
          else m_code = 2;
        end
        m_cnt++;
      end else if (m_cnt > 0) begin
        m_idle++;
        if (m_idle == TMO) m_code = 3;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [43:0] sb_item;
  always @(negedge clk) begin
    chk("rx_ready",   64'(rx_ready),   64'(reset && model_open()));
    chk("busy",       64'(busy),       64'(model_open() && m_cnt > 0));
    chk("core_reset", 64'(core_reset), 64'(!m_done));
    chk("error",      64'(error),      64'(m_code != 0));
    chk("err_code",   64'(err_code),   64'(m_code));
    chk("imem_we",    64'(imem_we),    64'(m_we));
    if (imem_we) begin
      wr_count++;
      chk("imem_addr",  64'(imem_addr),  64'(m_addr));
      chk("imem_wdata", 64'(imem_wdata), 64'(m_data));
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_write: got addr %0h data %0h, none expected", imem_addr, imem_wdata);
      end else begin
        sb_item = exp_q.pop_front();
        chk("sb_write", 64'({imem_addr, imem_wdata}), 64'(sb_item));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] d, input int gap);
    bit ok;
    int budget;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data = d;
    rx_valid = 1'b1;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 40) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte: byte %0h not accepted, rx_ready stayed %0b", d, rx_ready);
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic to_after_pos();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] fr[$];
  logic [7:0] xs;
  logic [31:0] w;
  int wc0;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rx_ready",   64'(rx_ready),   64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_error",      64'(error),      64'd0);
    chk("rst_err_code",   64'(err_code),   64'd0);
    chk("rst_imem_we",    64'(imem_we),    64'd0);
    chk("rst_imem_addr",  64'(imem_addr),  64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    to_after_pos();
    reset = 1'b1;
    to_after_pos();

    // Good N=2 frame, back-to-back. XOR of the eight payload bytes is 0xB0.
    exp_q.push_back({12'h000, 32'h0010_0513});
    exp_q.push_back({12'h004, 32'h0020_0593});
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
           8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    send_frame(fr);
    to_negedge();
    chk("t1_core_released", 64'(core_reset), 64'd0);
    chk("t1_err_code",      64'(err_code),   64'd0);
    chk("t1_ready_low",     64'(rx_ready),   64'd0);
    chk("t1_writes",        64'(wr_count),   64'd2);
    to_after_pos();

    // Byte offered in DONE, then start together with rx_valid: not accepted.
    rx_data = 8'h55;
    rx_valid = 1'b1;
    to_after_pos();
    pulse_start();
    rx_valid = 1'b0;
    to_negedge();
    chk("t1_restart_core_reset", 64'(core_reset), 64'd1);
    chk("t1_restart_busy",       64'(busy),       64'd0);
    chk("t1_restart_ready",      64'(rx_ready),   64'd1);
    to_after_pos();

    // Same payload, wrong checksum
    exp_q.push_back({12'h000, 32'h0010_0513});
    exp_q.push_back({12'h004, 32'h0020_0593});
    fr[12] = 8'h31;
    send_frame(fr);
    to_negedge();
    chk("t2_error",      64'(error),      64'd1);
    chk("t2_err_code",   64'(err_code),   64'd2);
    chk("t2_core_reset", 64'(core_reset), 64'd1);
    chk("t2_ready_low",  64'(rx_ready),   64'd0);
    to_after_pos();
    pulse_start();

    // N=1025 overflows a 1024-word memory
    wc0 = wr_count;
    fr = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_frame(fr);
    to_negedge();
    chk("t3_error",    64'(error),    64'd1);
    chk("t3_err_code", 64'(err_code), 64'd1);
    chk("t3_no_write", 64'(wr_count - wc0), 64'd0);
    to_after_pos();
    pulse_start();

    // N=1, stall after two payload bytes
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_frame(fr);
    repeat (15) @(posedge clk);
    #1;
    to_negedge();
    chk("t4_no_error_at_15", 64'(error), 64'd0);
    to_after_pos();
    to_negedge();
    chk("t4_error_at_16",  64'(error),    64'd1);
    chk("t4_err_code",     64'(err_code), 64'd3);
    to_after_pos();
    pulse_start();

    // N=8 with random gaps shorter than the timeout
    wc0 = wr_count;
    xs = 8'h00;
    send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      w = {8'(8'h40 + i), 8'(i * 17 + 1), 8'hC3, 8'(i)};
      exp_q.push_back({12'(i * 4), w});
      for (int b = 0; b < 4; b++) begin
        send_byte(w[b*8 +: 8], $urandom_range(0, 10));
        xs = xs ^ w[b*8 +: 8];
      end
    end
    send_byte(xs, $urandom_range(0, 10));
    to_negedge();
    chk("t5_core_released", 64'(core_reset),    64'd0);
    chk("t5_writes",        64'(wr_count - wc0), 64'd8);
    to_after_pos();
    pulse_start();

    // Reset in the middle of LOAD, then an error, then a clean N=0 frame
    exp_q.push_back({12'h000, 32'hEFBE_ADDE});
    fr = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22};
    send_frame(fr);
    reset = 1'b0;
    to_negedge();
    chk("t6_rst_core_reset", 64'(core_reset), 64'd1);
    chk("t6_rst_busy",       64'(busy),       64'd0);
    chk("t6_rst_ready",      64'(rx_ready),   64'd0);
    to_after_pos();
    reset = 1'b1;
    to_after_pos();
    wc0 = wr_count;
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_frame(fr);
    to_negedge();
    chk("t6_err_code", 64'(err_code), 64'd2);
    to_after_pos();
    pulse_start();
    fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fr);
    to_negedge();
    chk("t6_core_released", 64'(core_reset),     64'd0);
    chk("t6_err_code_done", 64'(err_code),       64'd0);
    chk("t6_no_write",      64'(wr_count - wc0), 64'd0);
    to_after_pos();

    repeat (3) to_after_pos();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
